// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants and types for the sequential RISC-V core:
//               major opcodes, the canonical NOP and the fetch FSM encoding.
//               The ERR fetch state exists only when MISALIGN_TRAP_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/pc_next_logic.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_logic
// Description : Combinational next-PC selection: sequential pc+4 (wrapping
//               modulo 2^XLEN) or the branch target. With MISALIGN_TRAP_EN
//               the raw target is passed through and a misalign flag is
//               produced; without it the target's low two bits are cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_logic
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_branch_target,
`ifdef MISALIGN_TRAP_EN
    output logic            o_misalign,
`endif
    output logic [XLEN-1:0] o_next_pc
);

    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_target;

    // Natural overflow of the adder gives the required wrap to zero.
    assign w_seq_pc = i_pc + XLEN'(4);

`ifdef MISALIGN_TRAP_EN
    // Keep the raw target so the faulting address is visible in pc.
    assign w_target   = i_branch_target;
    assign o_misalign = i_branch_taken && (i_branch_target[1:0] != 2'b00);
`else
    // Word-align the target silently.
    assign w_target   = i_branch_target & ~XLEN'(3);
`endif

    assign o_next_pc = i_branch_taken ? w_target : w_seq_pc;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage. Holds the PC, fetches one 32-bit instruction at
//               a time over a req/ready handshake and presents it until the
//               downstream datapath retires it, then advances sequentially
//               or to the branch target.
//               Optional feature macro: MISALIGN_TRAP_EN (sticky fetch_err
//               and absorbing ERR state on a misaligned taken branch).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    input  logic            instr_ready,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
`ifdef MISALIGN_TRAP_EN
    output logic            fetch_err,
`endif
    output logic [6:0]      opcode
);

    fetch_state_t    r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [31:0]     r_instr, w_instr_nxt;
    logic            r_valid, w_valid_nxt;
    logic [XLEN-1:0] w_next_pc;
`ifdef MISALIGN_TRAP_EN
    logic            r_fetch_err, w_fetch_err_nxt;
    logic            w_misalign;
`endif

    pc_next_logic #(
        .XLEN            (XLEN)
    ) u_pc_next_logic (
        .i_pc            (r_pc),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
`ifdef MISALIGN_TRAP_EN
        .o_misalign      (w_misalign),
`endif
        .o_next_pc       (w_next_pc)
    );

    // State and datapath registers; async reset returns everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_instr     <= NOP_INSTR;
            r_valid     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_fetch_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_instr     <= w_instr_nxt;
            r_valid     <= w_valid_nxt;
`ifdef MISALIGN_TRAP_EN
            r_fetch_err <= w_fetch_err_nxt;
`endif
        end
    end

    // Next-state and datapath update decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_instr_nxt     = r_instr;
        w_valid_nxt     = r_valid;
`ifdef MISALIGN_TRAP_EN
        w_fetch_err_nxt = r_fetch_err;
`endif
        case (r_state)
            S_REQ: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_ready) begin
                    w_instr_nxt = imem_rdata;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    w_valid_nxt = 1'b0;
                    w_pc_nxt    = w_next_pc;
`ifdef MISALIGN_TRAP_EN
                    if (w_misalign) begin
                        w_fetch_err_nxt = 1'b1;
                        w_state_nxt     = S_ERR;
                    end else begin
                        w_state_nxt     = S_REQ;
                    end
`else
                    w_state_nxt = S_REQ;
`endif
                end
            end
`ifdef MISALIGN_TRAP_EN
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
`endif
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // Request is a pure state decode, masked while reset is held so nothing
    // is requested before the first clock after release.
    assign imem_req    = rst_n && ((r_state == S_REQ) || (r_state == S_WAIT));
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    // Zero opcode while idle keeps control_unit at its all-zero default.
    assign opcode      = r_valid ? r_instr[6:0] : 7'b0000000;
`ifdef MISALIGN_TRAP_EN
    assign fetch_err   = r_fetch_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed bench for instr_fetch_unit. Stimulus pushes the
//               expected retired {pc, instr, opcode} into a queue; a monitor
//               pops and compares whenever an instruction is retired.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;
    logic            instr_ready;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            instr_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
`ifdef MISALIGN_TRAP_EN
    logic            fetch_err;
`endif

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [6:0]  opc;
    } exp_t;

    exp_t sb_q[$];
    int   n_total;
    int   n_pass;

    instr_fetch_unit #(
        .XLEN          (XLEN),
        .RESET_PC      (64'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .pc            (pc),
`ifdef MISALIGN_TRAP_EN
        .fetch_err     (fetch_err),
`endif
        .opcode        (opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] p, input logic [31:0] i, input logic [6:0] o);
        exp_t e;
        e.pc = p; e.instr = i; e.opc = o;
        sb_q.push_back(e);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !instr_valid; i++) step();
        chk("wait_valid", {63'd0, instr_valid}, 64'd1);
    endtask

    task automatic retire(input logic bt, input logic [63:0] tgt);
        wait_valid();
        instr_ready   = 1'b1;
        branch_taken  = bt;
        branch_target = tgt;
        step();
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
    endtask

    // Scoreboard monitor: one comparison set per retire cycle.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL retire_unexpected: got pc=%h instr=%h, expected no retire", pc, instr);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("retire_pc", pc, e.pc);
                chk("retire_instr", {32'd0, instr}, {32'd0, e.instr});
                chk("retire_opcode", {57'd0, opcode}, {57'd0, e.opc});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int opc_cnt;
        n_total = 0; n_pass = 0;
        rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h00000033;
        instr_ready = 1'b1; branch_taken = 1'b0; branch_target = '0;

        // Reset state
        step();
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_pc", pc, 64'h0);
        chk("rst_instr", {32'd0, instr}, 64'h13);
        chk("rst_opcode", {57'd0, opcode}, 64'd0);
        chk("rst_req", {63'd0, imem_req}, 64'd0);
`ifdef MISALIGN_TRAP_EN
        chk("rst_err", {63'd0, fetch_err}, 64'd0);
`endif

        // Back-to-back fetch: 3 cycles per instruction
        push(64'h0, 32'h00000033, 7'b0110011);
        push(64'h4, 32'h00000033, 7'b0110011);
        rst_n = 1'b1;
        opc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (opcode == 7'b0110011) opc_cnt++;
            if (i == 2) chk("seq_pc4", pc, 64'h4);
        end
        chk("seq_pc8", pc, 64'h8);
        chk("seq_opc_cycles", 64'(opc_cnt), 64'd2);

        // Memory stall in WAIT
        imem_ready = 1'b0; instr_ready = 1'b0; imem_rdata = 32'h00000003;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_req", {63'd0, imem_req}, 64'd1);
            chk("stall_addr", imem_addr, 64'h8);
        end
        chk("stall_valid", {63'd0, instr_valid}, 64'd0);
        imem_ready = 1'b1;
        step();
        chk("stall_valid_rise", {63'd0, instr_valid}, 64'd1);

        // Downstream stall in HOLD; memory traffic ignored
        imem_rdata = 32'h00000033;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_instr", {32'd0, instr}, 64'h3);
            chk("hold_pc", pc, 64'h8);
            chk("hold_opcode", {57'd0, opcode}, 64'h03);
            chk("hold_req", {63'd0, imem_req}, 64'd0);
        end

        // Taken branch at pc=8
        push(64'h8, 32'h00000003, 7'b0000011);
        retire(1'b1, 64'h100);
        imem_ready = 1'b0;
        chk("br_addr", imem_addr, 64'h100);
        chk("br_req", {63'd0, imem_req}, 64'd1);
        step();
        branch_taken = 1'b1; branch_target = 64'h200;
        step();
        branch_taken = 1'b0; branch_target = '0;
        imem_ready = 1'b1; imem_rdata = 32'h00000063;
        step();
        chk("wait_branch_ignored", pc, 64'h100);
        push(64'h100, 32'h00000063, 7'b1100011);
        retire(1'b0, 64'h0);
        chk("seq_after_br", pc, 64'h104);

        // Misaligned branch target
        push(64'h104, 32'h00000063, 7'b1100011);
        retire(1'b1, 64'h102);
`ifdef MISALIGN_TRAP_EN
        chk("mis_err", {63'd0, fetch_err}, 64'd1);
        chk("mis_valid", {63'd0, instr_valid}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mis_req_off", {63'd0, imem_req}, 64'd0);
        end
        chk("mis_pc", pc, 64'h102);
`else
        chk("mis_pc_aligned", pc, 64'h100);
        chk("mis_req", {63'd0, imem_req}, 64'd1);
`endif

        // Reset recovery
        rst_n = 1'b0;
        #1;
        chk("rst2_pc", pc, 64'h0);
        chk("rst2_valid", {63'd0, instr_valid}, 64'd0);
`ifdef MISALIGN_TRAP_EN
        chk("rst2_err", {63'd0, fetch_err}, 64'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h00000023;
        push(64'h0, 32'h00000023, 7'b0100011);
        retire(1'b0, 64'h0);
        chk("rst2_next_pc", pc, 64'h4);

        // Reset asserted mid-WAIT
        imem_ready = 1'b0;
        step();
        step();
        chk("midwait_req", {63'd0, imem_req}, 64'd1);
        rst_n = 1'b0;
        imem_ready = 1'b1;
        #1;
        chk("midrst_valid", {63'd0, instr_valid}, 64'd0);
        chk("midrst_opcode", {57'd0, opcode}, 64'd0);
        chk("midrst_req", {63'd0, imem_req}, 64'd0);
        chk("midrst_pc", pc, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(64'h0, 32'h00000023, 7'b0100011);
        retire(1'b0, 64'h0);
        chk("restart_pc", pc, 64'h4);

        step();
        step();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
